fetch_unit: RTL and testbench

Instruction-fetch stage for the 5-stage pipelined CPU: owns the program counter, talks to instruction memory over a req/ack handshake that tolerates multi-cycle latency, and drives the IF/ID pipeline register with a valid bit. It sits directly upstream of the ID stage. It accepts a stall from hazard logic and a branch redirect from the MEM stage, replacing the free-running PC, PC+4 adder, branch mux and plain IF/ID register.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word-aligned requests over a
// req/ack instruction-memory handshake with arbitrary latency, and loads the
// IF/ID pipeline register. Redirects from MEM take priority over stalls; a
// redirect that lands while a request is still outstanding waits in DROP
// until the stale response has been absorbed.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending_pc;
    logic [31:0] r_hold_buf;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_instr;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    // Branch targets are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    assign w_pc_plus4 = r_pc + 32'd4;          // wraps modulo 2^32
    assign w_target   = word_align(redirect_pc_i);

    // A request is outstanding in FETCH and DROP; HOLD already owns its data.
    // Reset forces the request low immediately, independent of the clock.
    assign imem_req_o   = rst_i & ((r_state == ST_FETCH) | (r_state == ST_DROP));
    assign imem_addr_o  = r_pc;
    assign ifid_valid_o = r_ifid_valid;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_instr_o = r_ifid_instr;

    // Fetch FSM: PC, pending redirect target, hold buffer and IF/ID register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_pending_pc <= RESET_PC;
            r_hold_buf   <= 32'h0000_0000;
            r_ifid_valid <= 1'b0;
            r_ifid_pc4   <= 32'h0000_0000;
            r_ifid_instr <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (redirect_i) begin
                        // Wrong-path fetch: squash IF/ID and steer the PC.
                        r_ifid_valid <= 1'b0;
                        if (imem_ack_i) begin
                            r_pc <= w_target;
                        end else begin
                            // Request still in flight; its response must be drained first.
                            r_pending_pc <= w_target;
                            r_state      <= ST_DROP;
                        end
                    end else if (stall_i) begin
                        if (imem_ack_i) begin
                            // Park the word so memory is not asked twice.
                            r_hold_buf <= imem_data_i;
                            r_state    <= ST_HOLD;
                        end
                    end else if (imem_ack_i) begin
                        r_ifid_valid <= 1'b1;
                        r_ifid_pc4   <= w_pc_plus4;
                        r_ifid_instr <= imem_data_i;
                        r_pc         <= w_pc_plus4;
                    end else begin
                        // Memory still busy: hand a bubble to ID.
                        r_ifid_valid <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (redirect_i) begin
                        r_ifid_valid <= 1'b0;
                        r_pc         <= w_target;
                        r_state      <= ST_FETCH;
                    end else if (!stall_i) begin
                        r_ifid_valid <= 1'b1;
                        r_ifid_pc4   <= w_pc_plus4;
                        r_ifid_instr <= r_hold_buf;
                        r_pc         <= w_pc_plus4;
                        r_state      <= ST_FETCH;
                    end
                end

                ST_DROP: begin
                    // Nothing from the stale request may reach ID; stall is irrelevant here.
                    r_ifid_valid <= 1'b0;
                    if (imem_ack_i) begin
                        r_pc    <= redirect_i ? w_target : r_pending_pc;
                        r_state <= ST_FETCH;
                    end else if (redirect_i) begin
                        r_pending_pc <= w_target;
                    end
                end

                default: begin
                    r_ifid_valid <= 1'b0;
                    r_state      <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory model
// pushes the expected IF/ID contents into a scoreboard whenever it returns a
// word that should be consumed; a monitor pops and compares each newly
// loaded IF/ID entry. A second instance with RESET_PC at the top of the
// address space checks PC wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'hDEAD_BEEF;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;

    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    logic [31:0] pc4_2;
    logic [31:0] instr2;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb_q[$];
    int          mem_lat = 0;
    int          mem_cnt = 0;
    logic        drop_flag = 1'b0;
    logic [31:0] a;
    logic [31:0] old_pc4;
    logic [31:0] old_instr;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .ifid_valid_o (ifid_valid_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_instr_o (ifid_instr_o)
    );

    fetch_unit #(.RESET_PC(WRAP_PC)) u_dut_wrap (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .stall_i      (1'b0),
        .redirect_i   (1'b0),
        .redirect_pc_i(32'h0000_0000),
        .imem_req_o   (req2),
        .imem_addr_o  (addr2),
        .imem_ack_i   (req2),
        .imem_data_i  (addr2 ^ 32'h1357_9BDF),
        .ifid_valid_o (valid2),
        .ifid_pc4_o   (pc4_2),
        .ifid_instr_o (instr2)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers mem_lat cycles after a request starts; schedules
    // expected IF/ID contents for every word that is not a wrong-path fetch.
    always @(negedge clk) begin
        if (!rst_i) begin
            imem_ack_i  = 1'b0;
            imem_data_i = 32'hDEAD_BEEF;
            mem_cnt     = 0;
            drop_flag   = 1'b0;
        end else if (!imem_req_o) begin
            imem_ack_i  = 1'b0;
            imem_data_i = 32'hDEAD_BEEF;
            mem_cnt     = 0;
        end else if (mem_cnt >= mem_lat) begin
            imem_ack_i  = 1'b1;
            imem_data_i = instr_of(imem_addr_o);
            mem_cnt     = 0;
            if (drop_flag)
                drop_flag = 1'b0;
            else if (!redirect_i)
                sb_q.push_back({imem_addr_o + 32'd4, instr_of(imem_addr_o)});
        end else begin
            imem_ack_i  = 1'b0;
            imem_data_i = 32'hDEAD_BEEF;
            mem_cnt++;
            if (redirect_i)
                drop_flag = 1'b1;
        end
    end

    // Monitor: an IF/ID entry is new whenever valid follows an unstalled edge.
    always @(posedge clk) begin : mon
        logic        s_stall;
        logic        s_rst;
        logic [63:0] e;
        s_stall = stall_i;
        s_rst   = rst_i;
        #1;
        if (s_rst && rst_i && ifid_valid_o && !s_stall) begin
            if (sb_q.size() == 0) begin
                check_value("sb_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_value("sb_pc4", ifid_pc4_o, e[63:32]);
                check_value("sb_instr", ifid_instr_o, e[31:0]);
            end
        end
    end

    initial begin
        rst_i         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0000_0000;
        mem_lat       = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_value("rst_req", 32'(imem_req_o), 32'd0);
        check_value("rst_valid", 32'(ifid_valid_o), 32'd0);
        check_value("rst_addr", imem_addr_o, 32'h0000_0000);
        check_value("rst_pc4", ifid_pc4_o, 32'h0000_0000);
        check_value("rst_instr", ifid_instr_o, 32'h0000_0000);
        check_value("rst_addr_wrap", addr2, WRAP_PC);
        rst_i = 1'b1;
        #1;
        check_value("first_req", 32'(imem_req_o), 32'd1);
        check_value("first_addr", imem_addr_o, 32'h0000_0000);
        check_value("first_addr_wrap", addr2, WRAP_PC);

        // Zero-wait streaming, plus wrap on the second instance
        tick();
        check_value("zw_valid", 32'(ifid_valid_o), 32'd1);
        check_value("zw_pc4", ifid_pc4_o, 32'd4);
        check_value("wrap_addr", addr2, 32'h0000_0000);
        check_value("wrap_pc4", pc4_2, 32'h0000_0000);
        check_value("wrap_instr", instr2, instr_of(WRAP_PC));
        for (int i = 2; i <= 6; i++) begin
            tick();
            check_value("zw_valid", 32'(ifid_valid_o), 32'd1);
            check_value("zw_pc4", ifid_pc4_o, 32'(4 * i));
        end

        // Two-cycle ack latency: address held for three cycles, valid 0,0,1
        #1;
        mem_lat = 2;
        a = imem_addr_o;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                check_value("lat_addr", imem_addr_o, a);
                check_value("lat_req", 32'(imem_req_o), 32'd1);
                tick();
                check_value("lat_valid", 32'(ifid_valid_o), (k == 2) ? 32'd1 : 32'd0);
            end
            a = a + 32'd4;
        end
        check_value("lat_next_addr", imem_addr_o, 32'h0000_0020);

        // Redirect to 0x100 (unaligned target) while 0x20 is outstanding
        tick();
        #1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick();
        check_value("drop_valid", 32'(ifid_valid_o), 32'd0);
        check_value("drop_addr", imem_addr_o, 32'h0000_0020);
        check_value("drop_req", 32'(imem_req_o), 32'd1);
        #1;
        redirect_i = 1'b0;
        tick();
        check_value("redir_addr", imem_addr_o, 32'h0000_0100);
        check_value("redir_valid", 32'(ifid_valid_o), 32'd0);

        // Second redirect while in DROP wins
        tick();
        #1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        tick();
        check_value("drop2_addr", imem_addr_o, 32'h0000_0100);
        #1;
        redirect_pc_i = 32'h0000_0200;
        tick();
        check_value("redir2_addr", imem_addr_o, 32'h0000_0200);
        check_value("redir2_valid", 32'(ifid_valid_o), 32'd0);
        #1;
        redirect_i = 1'b0;
        repeat (3) tick();
        check_value("redir2_fetch_valid", 32'(ifid_valid_o), 32'd1);
        check_value("redir2_fetch_pc4", ifid_pc4_o, 32'h0000_0204);

        // Redirect together with stall while IF/ID is valid
        #1;
        mem_lat       = 0;
        redirect_i    = 1'b1;
        stall_i       = 1'b1;
        redirect_pc_i = 32'h0000_0400;
        tick();
        check_value("rs_valid", 32'(ifid_valid_o), 32'd0);
        check_value("rs_addr", imem_addr_o, 32'h0000_0400);
        #1;
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        tick();
        check_value("rs_fetch_pc4", ifid_pc4_o, 32'h0000_0404);

        // Stall in the ack cycle for three cycles, then release
        #1;
        a         = imem_addr_o;
        old_pc4   = ifid_pc4_o;
        old_instr = ifid_instr_o;
        stall_i   = 1'b1;
        tick();
        check_value("hold_req", 32'(imem_req_o), 32'd0);
        check_value("hold_pc4", ifid_pc4_o, old_pc4);
        check_value("hold_instr", ifid_instr_o, old_instr);
        tick();
        check_value("hold_req", 32'(imem_req_o), 32'd0);
        tick();
        check_value("hold_pc4", ifid_pc4_o, old_pc4);
        #1;
        stall_i = 1'b0;
        tick();
        check_value("rel_valid", 32'(ifid_valid_o), 32'd1);
        check_value("rel_instr", ifid_instr_o, instr_of(a));
        check_value("rel_pc4", ifid_pc4_o, a + 32'd4);
        check_value("rel_req", 32'(imem_req_o), 32'd1);
        check_value("rel_addr", imem_addr_o, a + 32'd4);

        // Asynchronous reset pulse while a slow request is in flight
        #1;
        mem_lat = 3;
        tick();
        #1;
        rst_i = 1'b0;
        #1;
        check_value("arst_addr", imem_addr_o, 32'h0000_0000);
        check_value("arst_valid", 32'(ifid_valid_o), 32'd0);
        check_value("arst_req", 32'(imem_req_o), 32'd0);
        check_value("arst_addr_wrap", addr2, WRAP_PC);
        check_value("arst_valid_wrap", 32'(valid2), 32'd0);
        tick();
        check_value("arst_hold_addr", imem_addr_o, 32'h0000_0000);
        #1;
        rst_i   = 1'b1;
        mem_lat = 0;
        #1;
        check_value("arst_rel_req", 32'(imem_req_o), 32'd1);
        check_value("arst_rel_addr", imem_addr_o, 32'h0000_0000);
        tick();
        check_value("arst_first_pc4", ifid_pc4_o, 32'd4);

        // Drain: stop acking, let the last scheduled word retire
        #1;
        mem_lat = 1000;
        repeat (2) tick();
        check_value("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
